// File: rtl/eightbit_restoring_divider.sv
// Unsigned restoring divider: one quotient bit per clock, MSB first.
// Results appear on quotient/remainder only when the operation completes.
module eightbit_restoring_divider #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder,
  output logic              divzero
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] dvd_q;
  logic [DATA_W-1:0] dvs_q;
  logic [DATA_W-1:0] prem_q;

  logic [DATA_W:0]   trial;
  logic [DATA_W+1:0] sum;
  logic              ge;
  logic [DATA_W-1:0] prem_nxt;
  logic [DATA_W-1:0] quo_nxt;
  logic              accept;
  logic              last;
  logic              unused_sum_msb;

  // P + ~D + 1 over a 9-bit minuend; bit DATA_W+1 is the carry-out,
  // which is set exactly when P >= D.
  function automatic logic [DATA_W+1:0] sub_carry(
    input logic [DATA_W:0]   p,
    input logic [DATA_W-1:0] d
  );
    logic [DATA_W:0] dn;
    dn = ~{1'b0, d};
    return {1'b0, p} + {1'b0, dn} + {{(DATA_W+1){1'b0}}, 1'b1};
  endfunction

  assign accept = (state == IDLE) && start;
  assign last   = (state == RUN) && (cnt == CNT_W'(DATA_W - 1));

  always_comb begin
    trial    = {prem_q, dvd_q[DATA_W-1]};
    sum      = sub_carry(trial, dvs_q);
    ge       = sum[DATA_W+1];
    // After a successful subtract the difference is below the divisor,
    // and after a failed one the trial value is; either fits DATA_W bits.
    prem_nxt = ge ? sum[DATA_W-1:0] : trial[DATA_W-1:0];
    quo_nxt  = {dvd_q[DATA_W-2:0], ge};
  end

  assign unused_sum_msb = sum[DATA_W] ^ trial[DATA_W];

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      divzero   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (accept) begin
      cnt     <= '0;
      divzero <= (divisor == '0);
      if (divisor == '0) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      if (last) begin
        quotient  <= quo_nxt;
        remainder <= prem_nxt;
      end
    end
  end

  // Working registers: the dividend register shifts out dividend bits
  // and shifts in quotient bits, so it holds the quotient at the end.
  always_ff @(posedge clk) begin
    if (accept) begin
      dvd_q  <= dividend;
      dvs_q  <= divisor;
      prem_q <= '0;
    end else if (state == RUN) begin
      dvd_q  <= quo_nxt;
      prem_q <= prem_nxt;
    end
  end

endmodule
